// File: rtl/pps_rate_correction.sv
// pps_rate_correction
// Closed-loop DDS rate controller feeding the timestamp counter. Each PPS
// strobe delivers the 32.32 timestamp captured at that edge; the elapsed
// time between consecutive strobes is compared against exactly one second,
// and the DDS phase increment is nudged so the counter tracks true seconds.
// Intervals whose error is too large (e.g. a timestamp reload) are rejected.
//
// Ports
//   axi_aclk    clock, all logic on rising edge
//   axi_resetn  asynchronous active-low reset
//   time_pps    timestamp captured at PPS (32.32 seconds.fraction)
//   pps_valid   one-cycle PPS strobe
//   resync      drop the reference sample, keep the current dds_rate
//   dds_rate    DDS phase increment to the timestamp counter
//   locked      loop locked
//   outlier     one-cycle pulse: sample rejected
//   overrun     one-cycle pulse: pps_valid arrived while busy, ignored
//
// state   | meaning
// S_FIRST | no reference timestamp yet; next PPS becomes the reference
// S_IDLE  | reference held, waiting for the next PPS
// S_DIFF  | compute interval error against one second
// S_CHECK | outlier rejection, compute candidate increment
// S_APPLY | clamp and load dds_rate, update lock counting

module pps_rate_correction #(
    parameter int                     TIMESTAMP_WIDTH = 64,
    parameter int                     DDS_WIDTH       = 32,
    parameter logic [DDS_WIDTH-1:0]   DDS_NOMINAL     = 32'hD6BF94D5,
    parameter logic [DDS_WIDTH-1:0]   DDS_MIN         = 32'hD5BF94D5,
    parameter logic [DDS_WIDTH-1:0]   DDS_MAX         = 32'hD7BF94D5,
    parameter int                     GAIN_SHIFT      = 1,
    parameter logic [31:0]            ERR_LIMIT       = 32'h01000000,
    parameter logic [31:0]            LOCK_THRESH     = 32'h00000400,
    parameter int                     LOCK_COUNT      = 4
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] time_pps,
    input  logic                       pps_valid,
    input  logic                       resync,
    output logic [DDS_WIDTH-1:0]       dds_rate,
    output logic                       locked,
    output logic                       outlier,
    output logic                       overrun
);

    localparam int CW  = DDS_WIDTH + 2;
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam logic [TIMESTAMP_WIDTH-1:0] ONE_SEC = TIMESTAMP_WIDTH'(64'h1_0000_0000);
    localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_COUNT);

    typedef enum logic [2:0] {
        S_FIRST = 3'd0,
        S_IDLE  = 3'd1,
        S_DIFF  = 3'd2,
        S_CHECK = 3'd3,
        S_APPLY = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic        [TIMESTAMP_WIDTH-1:0] prev, cur;
    logic signed [TIMESTAMP_WIDTH-1:0] error;
    logic signed [CW-1:0]              cand;
    logic        [LCW-1:0]             lock_cnt;

    logic        [TIMESTAMP_WIDTH-1:0] err_mag;
    logic                              err_outlier, err_fine;
    logic signed [CW-1:0]              err_term, cand_calc;
    logic        [DDS_WIDTH-1:0]       cand_clamped;
    logic        [LCW-1:0]             lock_inc, lock_nxt;
    logic                              outlier_nxt, overrun_nxt;

    // Magnitude as unsigned; the most negative value maps to 2^63, which is
    // still correctly treated as an outlier.
    assign err_mag     = error[TIMESTAMP_WIDTH-1] ? (~error + 1'b1) : error;
    assign err_outlier = err_mag > TIMESTAMP_WIDTH'(ERR_LIMIT);
    assign err_fine    = err_mag <= TIMESTAMP_WIDTH'(LOCK_THRESH);

    // Accepted errors are bounded by ERR_LIMIT, so truncating the shifted
    // error to the candidate width preserves its value and sign.
    assign err_term  = $signed(CW'(error >>> GAIN_SHIFT));
    assign cand_calc = $signed({2'b00, dds_rate}) - err_term;

    always_comb begin
        cand_clamped = cand[DDS_WIDTH-1:0];
        if (cand < $signed({2'b00, DDS_MIN})) begin
            cand_clamped = DDS_MIN;
        end else if (cand > $signed({2'b00, DDS_MAX})) begin
            cand_clamped = DDS_MAX;
        end
    end

    assign lock_inc = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LCW'(1);
    assign lock_nxt = err_fine ? lock_inc : '0;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= S_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        outlier_nxt = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            S_FIRST: if (pps_valid) state_nxt = S_IDLE;
            S_IDLE:  if (pps_valid) state_nxt = S_DIFF;
            S_DIFF: begin
                overrun_nxt = pps_valid;
                state_nxt   = S_CHECK;
            end
            S_CHECK: begin
                overrun_nxt = pps_valid;
                outlier_nxt = err_outlier;
                state_nxt   = err_outlier ? S_IDLE : S_APPLY;
            end
            S_APPLY: begin
                overrun_nxt = pps_valid;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_FIRST;
        endcase
        // resync wins over everything, including a simultaneous strobe
        if (resync) begin
            state_nxt   = S_FIRST;
            outlier_nxt = 1'b0;
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            prev     <= '0;
            cur      <= '0;
            error    <= '0;
            cand     <= '0;
            dds_rate <= DDS_NOMINAL;
            lock_cnt <= '0;
            locked   <= 1'b0;
            outlier  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            outlier <= outlier_nxt;
            overrun <= overrun_nxt;
            if (resync) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    S_FIRST: if (pps_valid) prev <= time_pps;
                    S_IDLE:  if (pps_valid) cur <= time_pps;
                    S_DIFF: begin
                        error <= $signed(cur - prev - ONE_SEC);
                        prev  <= cur;
                    end
                    S_CHECK: begin
                        if (err_outlier) begin
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                        end else begin
                            cand <= cand_calc;
                        end
                    end
                    S_APPLY: begin
                        dds_rate <= cand_clamped;
                        lock_cnt <= lock_nxt;
                        locked   <= (lock_nxt == LOCK_FULL);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/pps_rate_correction.md
Name: pps_rate_correction

Overview:
- Closed-loop DDS rate controller directly upstream of the timestamp counter.
- Consumes the timestamp captured at each PPS edge and the one-cycle PPS strobe, and measures the elapsed timestamp per second against exactly 1 s (2^32 in 32.32 fixed point).
- Steers the 32-bit DDS phase increment that the counter adds every clock, so the timestamp tracks true seconds.
- Rejects outlier intervals, e.g. from a timestamp reload, and reports lock.

Parameters:
TIMESTAMP_WIDTH, 64, width of captured timestamp; 32.32 seconds.fraction format
DDS_WIDTH, 32, width of DDS phase increment
DDS_NOMINAL, 32'hD6BF94D5, reset increment (160 MHz clock, counter LSB = 2^-27 s)
DDS_MIN, 32'hD5BF94D5, lower clamp for dds_rate
DDS_MAX, 32'hD7BF94D5, upper clamp for dds_rate
GAIN_SHIFT, 1, arithmetic right shift applied to the error before correction
ERR_LIMIT, 32'h01000000, max |error| accepted (~3.9 ms); larger is an outlier
LOCK_THRESH, 32'h00000400, |error| at or below this counts toward lock
LOCK_COUNT, 4, consecutive good samples required to assert locked

Ports:
axi_aclk  in  1  clock; all logic on rising edge
axi_resetn  in  1  asynchronous active-low reset
time_pps  in  TIMESTAMP_WIDTH  timestamp captured at PPS; valid when pps_valid=1
pps_valid  in  1  single-cycle strobe, one per second
resync  in  1  synchronous: discard reference sample, keep current dds_rate
dds_rate  out  DDS_WIDTH  DDS phase increment to the timestamp counter
locked  out  1  loop locked
outlier  out  1  one-cycle pulse: sample rejected, |error| > ERR_LIMIT
overrun  out  1  one-cycle pulse: pps_valid arrived while busy, sample ignored

Behaviour:
- Reset (async assert, sync-safe deassert): dds_rate=DDS_NOMINAL, locked=0, outlier=0, overrun=0, lock_cnt=0, prev/cur/error regs=0, state=S_FIRST.
- S_FIRST (no reference): on pps_valid, prev<=time_pps and go to S_IDLE. No correction, no pulses.
- S_IDLE: on pps_valid, cur<=time_pps and go to S_DIFF.
- S_DIFF: error<=cur-prev-2^32, with 64-bit modulo subtraction interpreted as signed. prev<=cur. Go to S_CHECK.
- S_CHECK:
  - If |error|>ERR_LIMIT: outlier=1 for one cycle, lock_cnt<=0, locked<=0, dds_rate unchanged, go to S_IDLE. The sample stays as the new reference.
  - Otherwise: cand<=dds_rate-(error>>>GAIN_SHIFT), computed in 34-bit signed with operands sign-extended. Go to S_APPLY.
- S_APPLY:
  - dds_rate<=clamp(cand,DDS_MIN,DDS_MAX).
  - If |error|<=LOCK_THRESH, lock_cnt<=min(lock_cnt+1,LOCK_COUNT); otherwise lock_cnt<=0.
  - locked<=(next lock_cnt==LOCK_COUNT).
  - Go to S_IDLE.
- Latency: pps_valid sampled at edge N, dds_rate updated at edge N+3. Throughput is one sample per 4 cycles; real PPS spacing is ~1.6e8 cycles.
- pps_valid in S_DIFF, S_CHECK or S_APPLY: ignored, overrun=1 for one cycle, state unaffected.
- resync=1 in any state: next state S_FIRST, lock_cnt<=0, locked<=0, dds_rate held, any in-flight sample aborted. resync beats a simultaneous pps_valid, which is dropped without overrun.
- Sign convention: timestamp running fast gives error>0 and dds_rate decreases; running slow gives error<0 and dds_rate increases.
- Clamp is inclusive. Hitting a clamp is not an error and does not affect lock counting.
- Wrap-around: time_pps crossing 2^64 still yields the correct delta through modulo subtraction.
- Async reset mid-operation returns immediately to reset values; no partial update of dds_rate.

Test Plan:
- Reset, then PPS at times 0x5_00000000 then 0x6_00000000 -> dds_rate stays 0xD6BF94D5 after edge N+3; lock_cnt=1; outlier=0.
- Second PPS at 0x6_00001000 (error +0x1000), GAIN_SHIFT=1 -> dds_rate=0xD6BF8CD5 at edge N+3; lock_cnt=0 (error > LOCK_THRESH).
- Second PPS at 0x5_FFFFF800 (error -0x800) -> dds_rate=0xD6BF98D5.
- Five consecutive intervals with error 0x100 -> locked rises after the 4th accepted sample. A following interval of 0x2_00000000 -> outlier pulse, locked=0, dds_rate unchanged, and the next 1 s interval is accepted.
- Error -0x08000000: outlier. Error -0x00FFFFFF repeated, with DDS_MAX overridden to DDS_NOMINAL+0x100 -> dds_rate clamps to exactly DDS_MAX.
- Assert pps_valid in S_DIFF -> overrun pulse, result unaffected. resync mid-S_CHECK -> no update, back to S_FIRST, next PPS only captures the reference. prev=0xFFFFFFFF_80000000 then cur=0x00000000_80000000 -> error 0, no change.
